// File: rtl/imm_pack.sv
// imm_pack: immediate encoder, the inverse of the RISC-V immediate extender.
// Takes a 32-bit immediate, an ImmSrc format code and a base instruction word.
// Packs the immediate into that format's bit positions and returns the finished
// instruction word.
// The datapath is a two-stage valid/ready pipeline:
//   S1 registers the request and the range verdict.
//   S2 registers the packed word.
// Configuration macro: IMM_RANGE_CHECK_EN
//   defined   -> S1 range logic is built and ImmErr flags unrepresentable immediates.
//   undefined -> no range logic is built and ImmErr is constant 0.
`timescale 1ns/1ps

module imm_pack #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             InValid,
  output logic             InReady,
  input  logic [2:0]       ImmSrc,
  input  logic [31:0]      ImmVal,
  input  logic [31:0]      BaseInstr,
  output logic             OutValid,
  input  logic             OutReady,
  output logic [31:0]      Instr,
  output logic             ImmErr,
  output logic [CNT_W-1:0] EncCount
);

  typedef enum logic [2:0] {
    IMM_I = 3'b000,
    IMM_S = 3'b001,
    IMM_B = 3'b010,
    IMM_J = 3'b011,
    IMM_U = 3'b100
  } imm_src_t;

  logic        s1_valid;
  imm_src_t    s1_src;
  logic [31:0] s1_val;
  logic [31:0] s1_base;
  logic        s1_err;
  logic        s1_load;
  logic        s2_load;
  logic        range_err;
  logic [31:0] packed_instr;

  // Stall control.
  // InReady depends combinationally on OutReady, so a full pipe can still
  // take a new word in the same cycle it hands one out.
  assign s2_load = !OutValid || OutReady;
  assign s1_load = !s1_valid || s2_load;
  assign InReady = s1_load;

`ifdef IMM_RANGE_CHECK_EN
  // Range check on the incoming request; its verdict is registered in S1.
  always_comb begin
    // NOTE: every output of an always_comb gets a default first, so no path can leave it unassigned and infer a latch.
    range_err = 1'b1;
    case (ImmSrc)
      IMM_I, IMM_S: range_err = !(&ImmVal[31:11] || ~|ImmVal[31:11]);
      IMM_B:        range_err = !(&ImmVal[31:12] || ~|ImmVal[31:12]) || ImmVal[0];
      IMM_J:        range_err = !(&ImmVal[31:20] || ~|ImmVal[31:20]) || ImmVal[0];
      IMM_U:        range_err = |ImmVal[11:0];
      default:      range_err = 1'b1;
    endcase
  end
`else
  assign range_err = 1'b0;
`endif

  // S1: capture the request and its range verdict when the stage can advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
      s1_valid <= 1'b0;
      s1_src   <= IMM_I;
      s1_val   <= '0;
      s1_base  <= '0;
      s1_err   <= 1'b0;
    end else if (s1_load) begin
      s1_valid <= InValid;
      if (InValid) begin
        s1_src  <= imm_src_t'(ImmSrc);
        s1_val  <= ImmVal;
        s1_base <= BaseInstr;
        s1_err  <= range_err;
      end
    end
  end

  // Pack the S1 immediate into the base word.
  // An unknown format passes the base through unchanged.
  always_comb begin
    packed_instr = s1_base;
    case (s1_src)
      IMM_I: packed_instr[31:20] = s1_val[11:0];
      IMM_S: begin
        packed_instr[31:25] = s1_val[11:5];
        packed_instr[11:7]  = s1_val[4:0];
      end
      IMM_B: begin
        packed_instr[31]    = s1_val[12];
        packed_instr[7]     = s1_val[11];
        packed_instr[30:25] = s1_val[10:5];
        packed_instr[11:8]  = s1_val[4:1];
      end
      IMM_J: begin
        packed_instr[31]    = s1_val[20];
        packed_instr[19:12] = s1_val[19:12];
        packed_instr[20]    = s1_val[11];
        packed_instr[30:21] = s1_val[10:1];
      end
      IMM_U:   packed_instr[31:12] = s1_val[31:12];
      default: packed_instr = s1_base;
    endcase
  end

  // S2: output register.
  // It only loads when empty or draining, so the outputs hold during backpressure.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the datapath registers are reset as well as the valid bits, because Instr must read 0 out of reset.
      OutValid <= 1'b0;
      Instr    <= '0;
      ImmErr   <= 1'b0;
    end else if (s2_load) begin
      OutValid <= s1_valid;
      if (s1_valid) begin
        Instr  <= packed_instr;
        ImmErr <= s1_err;
      end
    end
  end

  // Count delivered words, erroneous ones included; wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      EncCount <= '0;
    end else if (OutValid && OutReady) begin
      EncCount <= EncCount + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_imm_pack.sv
// tb_imm_pack: directed table plus hand-written sequences for imm_pack.
// An in-order scoreboard checks every delivered word.
// Directed words are compared exactly; random words are round-tripped through
// a reference immediate extender.
`timescale 1ns/1ps

module tb_imm_pack;

  logic        clk = 1'b0;
  logic        reset;
  logic        InValid, InReady, OutValid, OutReady, ImmErr;
  logic [2:0]  ImmSrc;
  logic [31:0] ImmVal, BaseInstr, Instr;
  logic [15:0] EncCount;

  int checks = 0;
  int errors = 0;
  int n_out  = 0;
  int n_acc  = 0;
  bit stream_done;

  typedef struct {
    logic [2:0]  src;
    logic [31:0] val;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
  } vec_t;

  typedef struct {
    bit          rt;
    logic [2:0]  src;
    logic [31:0] val;
    logic [31:0] base;
    logic [31:0] instr;
    logic        err;
  } exp_t;

  vec_t vecs[14];
  exp_t q[$];

  imm_pack #(.CNT_W(16)) dut (
    .clk(clk), .reset(reset), .InValid(InValid), .InReady(InReady),
    .ImmSrc(ImmSrc), .ImmVal(ImmVal), .BaseInstr(BaseInstr),
    .OutValid(OutValid), .OutReady(OutReady), .Instr(Instr),
    .ImmErr(ImmErr), .EncCount(EncCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_err(input logic e);
`ifdef IMM_RANGE_CHECK_EN
    return e;
`else
    return 1'b0;
`endif
  endfunction

  // Reference immediate extender (decoder side).
  function automatic logic [31:0] extend(input logic [31:0] i, input logic [2:0] src);
    case (src)
      3'b000:  return {{20{i[31]}}, i[31:20]};
      3'b001:  return {{20{i[31]}}, i[31:25], i[11:7]};
      3'b010:  return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
      3'b011:  return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
      default: return {i[31:12], 12'h000};
    endcase
  endfunction

  function automatic logic [31:0] imm_mask(input logic [2:0] src);
    case (src)
      3'b000:  return 32'hFFF0_0000;
      3'b001,
      3'b010:  return 32'hFE00_0F80;
      default: return 32'hFFFF_F000;
    endcase
  endfunction

  function automatic logic [31:0] legal_imm(input logic [2:0] src, input logic [31:0] r);
    case (src)
      3'b000, 3'b001: return {{20{r[11]}}, r[11:0]};
      3'b010:         return {{19{r[12]}}, r[12:1], 1'b0};
      3'b011:         return {{11{r[20]}}, r[20:1], 1'b0};
      default:        return {r[31:12], 12'h000};
    endcase
  endfunction

  task automatic push_exact(input vec_t v);
    exp_t e;
    e.rt = 1'b0; e.src = v.src; e.val = v.val; e.base = v.base;
    e.instr = v.instr; e.err = exp_err(v.err);
    q.push_back(e);
  endtask

  task automatic push_rt(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b);
    exp_t e;
    e.rt = 1'b1; e.src = s; e.val = v; e.base = b; e.instr = '0; e.err = 1'b0;
    q.push_back(e);
  endtask

  // Called at posedge+1; returns at posedge+1 right after the accepting edge.
  task automatic send(input logic [2:0] s, input logic [31:0] v, input logic [31:0] b);
    int waited = 0;
    InValid = 1'b1; ImmSrc = s; ImmVal = v; BaseInstr = b;
    @(negedge clk);
    while (!InReady && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!InReady) begin
      checks++; errors++;
      $display("FAIL send_timeout: InReady stayed 0 for %0d cycles, required 1", waited);
    end
    @(posedge clk); #1;
    InValid = 1'b0;
    n_acc++;
  endtask

  task automatic drain(input int budget);
    int c = 0;
    while ((q.size() != 0 || OutValid) && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    check("drain_queue", q.size(), 0);
    check("drain_outvalid", {31'b0, OutValid}, 0);
  endtask

  // Output monitor: scoreboard, hold stability and the EncCount model.
  logic        held_v = 1'b0;
  logic [31:0] held_instr;
  logic        held_err;
  exp_t        e;
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      held_v = 1'b0;
      n_out  = 0;
    end else begin
      if (held_v) begin
        check("hold_valid", {31'b0, OutValid}, 1);
        check("hold_instr", Instr, held_instr);
        check("hold_err", {31'b0, ImmErr}, {31'b0, held_err});
        held_v = 1'b0;
      end
      if (OutValid && !OutReady) begin
        held_v = 1'b1; held_instr = Instr; held_err = ImmErr;
      end
      if (OutValid && OutReady) begin
        check("enc_count", {16'b0, EncCount}, n_out & 32'hFFFF);
        n_out++;
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_out: got Instr %h, required no output", Instr);
        end else begin
          e = q.pop_front();
          if (e.rt) begin
            check("rt_imm", extend(Instr, e.src), e.val);
            check("rt_base", Instr & ~imm_mask(e.src), e.base & ~imm_mask(e.src));
            check("rt_err", {31'b0, ImmErr}, 0);
          end else begin
            check("instr", Instr, e.instr);
            check("imm_err", {31'b0, ImmErr}, {31'b0, e.err});
          end
        end
      end
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    int cnt_before;
    vecs[0]  = '{3'b000, 32'hFFFF_F800, 32'h0000_0013, 32'h8000_0013, 1'b0};
    vecs[1]  = '{3'b000, 32'h0000_0800, 32'h0000_0013, 32'h8000_0013, 1'b1};
    vecs[2]  = '{3'b000, 32'h0000_0000, 32'hFFFF_FFFF, 32'h000F_FFFF, 1'b0};
    vecs[3]  = '{3'b001, 32'hFFFF_FFFC, 32'h0000_2023, 32'hFE00_2E23, 1'b0};
    vecs[4]  = '{3'b001, 32'h0000_0800, 32'h0000_0023, 32'h8000_0023, 1'b1};
    vecs[5]  = '{3'b010, 32'hFFFF_FFFE, 32'h0000_0063, 32'hFE00_0FE3, 1'b0};
    vecs[6]  = '{3'b010, 32'h0000_1000, 32'h0000_0063, 32'h8000_0063, 1'b1};
    vecs[7]  = '{3'b011, 32'h0000_0003, 32'h0000_006F, 32'h0020_006F, 1'b1};
    vecs[8]  = '{3'b011, 32'hFFFF_FFFE, 32'h0000_006F, 32'hFFFF_F06F, 1'b0};
    vecs[9]  = '{3'b100, 32'h1234_5000, 32'h0000_0037, 32'h1234_5037, 1'b0};
    vecs[10] = '{3'b100, 32'h0000_0001, 32'h0000_0037, 32'h0000_0037, 1'b1};
    vecs[11] = '{3'b110, 32'hFFFF_FFFF, 32'h1234_5678, 32'h1234_5678, 1'b1};
    vecs[12] = '{3'b101, 32'h0000_0005, 32'h0000_0000, 32'h0000_0000, 1'b1};
    vecs[13] = '{3'b111, 32'h0000_0000, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b1};

    reset = 1'b1; InValid = 1'b0; OutReady = 1'b1;
    ImmSrc = '0; ImmVal = '0; BaseInstr = '0;
    @(negedge clk);
    check("rst_outvalid", {31'b0, OutValid}, 0);
    check("rst_instr", Instr, 0);
    check("rst_imm_err", {31'b0, ImmErr}, 0);
    check("rst_enc_count", {16'b0, EncCount}, 0);
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    check("rst_inready", {31'b0, InReady}, 1);
    @(posedge clk); #1;

    // Latency: accepted at edge 1, in S1 after edge 1, in S2 after edge 2.
    push_exact(vecs[0]);
    send(vecs[0].src, vecs[0].val, vecs[0].base);
    @(negedge clk);
    check("lat_after_1", {31'b0, OutValid}, 0);
    @(posedge clk); #1;
    @(negedge clk);
    check("lat_after_2", {31'b0, OutValid}, 1);
    @(posedge clk); #1;

    // Directed table, streamed back to back.
    for (int i = 0; i < 14; i++) begin
      push_exact(vecs[i]);
      send(vecs[i].src, vecs[i].val, vecs[i].base);
    end
    drain(50);
    check("count_after_table", {16'b0, EncCount}, 15);

    // Backpressure: 8 words with the consumer stalled for 5 cycles.
    cnt_before = n_out;
    n_acc = 0;
    OutReady = 1'b0;
    fork
      begin
        for (int i = 0; i < 8; i++) begin
          push_exact(vecs[i + 3]);
          send(vecs[i + 3].src, vecs[i + 3].val, vecs[i + 3].base);
        end
      end
      begin
        repeat (5) @(negedge clk);
        check("bp_accepts", n_acc, 2);
        check("bp_inready", {31'b0, InReady}, 0);
        @(posedge clk); #1;
        OutReady = 1'b1;
      end
    join
    drain(50);
    check("bp_count", {16'b0, EncCount}, (cnt_before + 8) & 32'hFFFF);

    // Asynchronous reset while a stalled word is being presented.
    OutReady = 1'b0;
    push_exact(vecs[0]);
    send(vecs[0].src, vecs[0].val, vecs[0].base);
    push_exact(vecs[1]);
    send(vecs[1].src, vecs[1].val, vecs[1].base);
    @(negedge clk);
    check("mid_pre_outvalid", {31'b0, OutValid}, 1);
    #1 reset = 1'b1;
    #1;
    check("mid_outvalid", {31'b0, OutValid}, 0);
    check("mid_instr", Instr, 0);
    check("mid_enc_count", {16'b0, EncCount}, 0);
    check("mid_imm_err", {31'b0, ImmErr}, 0);
    @(negedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    OutReady = 1'b1;
    @(negedge clk);
    check("mid_inready", {31'b0, InReady}, 1);
    @(posedge clk); #1;

    // Random legal round trip, long enough to wrap EncCount past 0xFFFF.
    stream_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 65541; i++) begin
          logic [2:0]  s;
          logic [31:0] v, b;
          s = 3'($urandom_range(4));
          v = legal_imm(s, $urandom);
          b = $urandom;
          push_rt(s, v, b);
          send(s, v, b);
        end
        stream_done = 1'b1;
      end
      begin
        while (!stream_done) begin
          @(posedge clk); #1;
          OutReady = ($urandom_range(15) != 0);
        end
        OutReady = 1'b1;
      end
    join
    drain(100);
    check("wrap_count", {16'b0, EncCount}, 5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
